// File: rtl/data_bus_responder_if.sv
// ---------------------------------------------------------------------------
// data_bus_responder_if
//   Groups the request/response pins between the core's bus controller
//   (master) and the data RAM responder (slave).
//
//   Request (master -> slave):
//     req_w      store request
//     req_r      load request
//     req_size   00 byte, 01 half, 10 word, 11 illegal
//     req_addr   byte address
//     req_wdata  right-aligned store data
//   Response (slave -> master):
//     rsp_ready  idle, a request may be accepted this cycle
//     rsp_busy   request accepted, not yet completed
//     rsp_valid  one-cycle completion pulse
//     rsp_rdata  right-aligned, zero-extended load data
//     rsp_fault  qualifies rsp_valid: request was rejected
//     fault_addr address of the most recent faulting request
// ---------------------------------------------------------------------------
interface data_bus_responder_if;
  logic        req_w;
  logic        req_r;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        rsp_busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] fault_addr;

  modport master (
    output req_w, req_r, req_size, req_addr, req_wdata,
    input  rsp_ready, rsp_busy, rsp_valid, rsp_rdata, rsp_fault, fault_addr
  );

  modport slave (
    input  req_w, req_r, req_size, req_addr, req_wdata,
    output rsp_ready, rsp_busy, rsp_valid, rsp_rdata, rsp_fault, fault_addr
  );
endinterface

// File: rtl/data_bus_responder.sv
// ---------------------------------------------------------------------------
// data_bus_responder
//   Target side of the core's data bus. Serves byte/half/word loads and
//   stores from an internal word-organised RAM of 2^DATA_ADDR_WIDTH words
//   mapped at BASE_ADDR. After reset the RAM is cleared one word per cycle
//   before the first request is accepted.
//
//   Parameters:
//     DATA_ADDR_WIDTH  word-address width (RAM depth = 2^DATA_ADDR_WIDTH)
//     BASE_ADDR        byte address of word 0 (4-byte aligned)
//     WAIT_STATES      extra cycles between acceptance and response (0..15)
//
//   Ports:
//     clk  single clock, rising edge
//     rst  synchronous active-high reset
//     bus  slave side of data_bus_responder_if (request/response pins)
// ---------------------------------------------------------------------------
module data_bus_responder #(
  parameter int unsigned DATA_ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int unsigned WAIT_STATES     = 1
) (
  input logic                  clk,
  input logic                  rst,
  data_bus_responder_if.slave  bus
);

  localparam int unsigned DEPTH     = 1 << DATA_ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic [DATA_ADDR_WIDTH-1:0] r_initCnt;
  logic [3:0]                 r_waitCnt;

  logic                       r_isWrite;
  logic [1:0]                 r_size;
  logic [1:0]                 r_lane;
  logic [DATA_ADDR_WIDTH-1:0] r_index;
  logic [31:0]                r_wdata;
  logic                       r_fault;
  logic [31:0]                r_rdata;
  logic [31:0]                r_faultAddr;

  logic [31:0]                r_mem [DEPTH];

  logic                       w_accept;
  logic [31:0]                w_offset;
  logic                       w_outOfRange;
  logic                       w_reqFault;
  logic                       w_ready;
  logic                       w_busy;
  logic                       w_valid;
  logic [31:0]                w_memWord;
  logic [31:0]                w_loadData;
  logic [31:0]                w_respData;
  logic [3:0]                 w_byteEn;
  logic [31:0]                w_storeData;
  logic                       w_doStore;

  // A request is taken only in IDLE; in every other state the request pins
  // are ignored, so a request held across RESP is simply taken again once
  // the FSM is back in IDLE.
  assign w_accept = (r_state == IDLE) && (bus.req_w || bus.req_r);

  // Fault decode on the live request. The offset from BASE_ADDR gives both
  // the word index and the byte lane; an address below BASE_ADDR or an
  // offset with any bit set above the index field lies outside the RAM.
  always_comb begin
    w_offset     = bus.req_addr - BASE_ADDR;
    w_outOfRange = (bus.req_addr < BASE_ADDR) ||
                   (w_offset[31:DATA_ADDR_WIDTH+2] != '0);
    w_reqFault   = (bus.req_w && bus.req_r) ||
                   (bus.req_size == 2'b11) ||
                   ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00)) ||
                   w_outOfRange;
  end

  // State register. Reset always wins, so an in-flight access is dropped
  // and the RAM clear sequence restarts from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and status outputs. INIT walks the clear counter to the last
  // word; IDLE offers ready; WAIT burns the configured wait states; RESP is
  // the single completion cycle.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      INIT: begin
        if (r_initCnt == '1) begin
          w_nextState = IDLE;
        end
      end
      IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          w_nextState = (WAIT_STATES != 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        w_busy = 1'b1;
        if (r_waitCnt == 4'd0) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_busy      = 1'b1;
        w_valid     = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = INIT;
      end
    endcase
  end

  // Request capture, counters and the held response registers. The fault
  // address is captured at acceptance and held until the next fault; the
  // read data register remembers whatever was presented during the last
  // RESP so rsp_rdata stays stable between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_initCnt   <= '0;
      r_waitCnt   <= 4'd0;
      r_isWrite   <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_index     <= '0;
      r_wdata     <= 32'h0;
      r_fault     <= 1'b0;
      r_rdata     <= 32'h0;
      r_faultAddr <= 32'h0;
    end else begin
      if (r_state == INIT) begin
        r_initCnt <= r_initCnt + 1'b1;
      end
      if (w_accept) begin
        r_isWrite <= bus.req_w;
        r_size    <= bus.req_size;
        r_lane    <= w_offset[1:0];
        r_index   <= w_offset[DATA_ADDR_WIDTH+1:2];
        r_wdata   <= bus.req_wdata;
        r_fault   <= w_reqFault;
        r_waitCnt <= WAIT_LOAD;
        if (w_reqFault) begin
          r_faultAddr <= bus.req_addr;
        end
      end else if ((r_state == WAIT) && (r_waitCnt != 4'd0)) begin
        r_waitCnt <= r_waitCnt - 4'd1;
      end
      if (r_state == RESP) begin
        r_rdata <= w_respData;
      end
    end
  end

  // Load path. The addressed word is read asynchronously from the latched
  // index, and the selected lane(s) are moved down to bit 0. A half access
  // always starts on an even lane, so only lane bit 1 selects the half.
  // A faulting request returns zero; a store leaves the old data in place.
  always_comb begin
    w_memWord  = r_mem[r_index];
    w_loadData = 32'h0;
    case (r_size)
      2'b00:   w_loadData = {24'h0, w_memWord[{r_lane, 3'b000} +: 8]};
      2'b01:   w_loadData = {16'h0, w_memWord[{r_lane[1], 4'b0000} +: 16]};
      2'b10:   w_loadData = w_memWord;
      default: w_loadData = 32'h0;
    endcase
    if (r_fault) begin
      w_respData = 32'h0;
    end else if (r_isWrite) begin
      w_respData = r_rdata;
    end else begin
      w_respData = w_loadData;
    end
  end

  // Store path. Right-aligned store data is replicated across the word so
  // every lane already carries the right bits; the byte enables then pick
  // which lanes actually change.
  always_comb begin
    w_byteEn    = 4'b0000;
    w_storeData = r_wdata;
    case (r_size)
      2'b00: begin
        w_byteEn    = 4'b0001 << r_lane;
        w_storeData = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_byteEn    = 4'b0011 << {r_lane[1], 1'b0};
        w_storeData = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_byteEn    = 4'b1111;
        w_storeData = r_wdata;
      end
      default: begin
        w_byteEn    = 4'b0000;
        w_storeData = r_wdata;
      end
    endcase
    w_doStore = (r_state == RESP) && r_isWrite && !r_fault;
  end

  // RAM write port, shared by the clear sequence and committed stores.
  // Writes are suppressed while reset is asserted so a store caught in
  // RESP by a reset leaves no partial update behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) begin
        r_mem[r_initCnt] <= 32'h0;
      end else if (w_doStore) begin
        for (int i = 0; i < 4; i++) begin
          if (w_byteEn[i]) begin
            r_mem[r_index][8*i +: 8] <= w_storeData[8*i +: 8];
          end
        end
      end
    end
  end

  // Response pins. rsp_rdata shows the live response only during RESP and
  // the held value otherwise.
  assign bus.rsp_ready  = w_ready;
  assign bus.rsp_busy   = w_busy;
  assign bus.rsp_valid  = w_valid;
  assign bus.rsp_fault  = w_valid && r_fault;
  assign bus.rsp_rdata  = (r_state == RESP) ? w_respData : r_rdata;
  assign bus.fault_addr = r_faultAddr;

endmodule

// File: tb/tb_data_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_data_bus_responder
//   Three responders with a 16-word RAM and 0, 1 and 3 wait states share
//   one set of request pins. The 1-wait-state instance is the main target
//   of the data checks; the other two give the latency and busy spans.
// ---------------------------------------------------------------------------
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqW = 1'b0;
  logic        reqR = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_responder_if busMain ();
  data_bus_responder_if busWs0 ();
  data_bus_responder_if busWs3 ();

  assign busMain.req_w     = reqW;
  assign busMain.req_r     = reqR;
  assign busMain.req_size  = reqSize;
  assign busMain.req_addr  = reqAddr;
  assign busMain.req_wdata = reqWdata;
  assign busWs0.req_w      = reqW;
  assign busWs0.req_r      = reqR;
  assign busWs0.req_size   = reqSize;
  assign busWs0.req_addr   = reqAddr;
  assign busWs0.req_wdata  = reqWdata;
  assign busWs3.req_w      = reqW;
  assign busWs3.req_r      = reqR;
  assign busWs3.req_size   = reqSize;
  assign busWs3.req_addr   = reqAddr;
  assign busWs3.req_wdata  = reqWdata;

  data_bus_responder #(.DATA_ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(1))
    dutMain (.clk(clk), .rst(rst), .bus(busMain));
  data_bus_responder #(.DATA_ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0))
    dutWs0 (.clk(clk), .rst(rst), .bus(busWs0));
  data_bus_responder #(.DATA_ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3))
    dutWs3 (.clk(clk), .rst(rst), .bus(busWs3));

  typedef struct {
    logic        w;
    logic        r;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expFault;
    logic [31:0] expFa;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int          latMain, latWs0, latWs3;
  int          busyMain, busyWs0, busyWs3;
  logic [31:0] rdMain, rdWs0;
  logic        fMain;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one request once all three responders are ready, then watches
  // eight falling edges recording latency, busy span and response data.
  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d);
    int   waited;
    logic allReady;
    waited = 0;
    @(negedge clk);
    allReady = busMain.rsp_ready && busWs0.rsp_ready && busWs3.rsp_ready;
    while (!allReady && waited < 40) begin
      @(negedge clk);
      waited++;
      allReady = busMain.rsp_ready && busWs0.rsp_ready && busWs3.rsp_ready;
    end
    checkOutput("readyBeforeReq", {31'h0, allReady}, 32'h1);
    reqW = w; reqR = r; reqSize = sz; reqAddr = a; reqWdata = d;
    @(posedge clk);
    #1;
    reqW = 1'b0; reqR = 1'b0;
    latMain = 0; latWs0 = 0; latWs3 = 0;
    busyMain = 0; busyWs0 = 0; busyWs3 = 0;
    rdMain = 32'hxxxx_xxxx; rdWs0 = 32'hxxxx_xxxx; fMain = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busMain.rsp_valid && latMain == 0) begin
        latMain = k; rdMain = busMain.rsp_rdata; fMain = busMain.rsp_fault;
      end
      if (busWs0.rsp_valid && latWs0 == 0) begin
        latWs0 = k; rdWs0 = busWs0.rsp_rdata;
      end
      if (busWs3.rsp_valid && latWs3 == 0) latWs3 = k;
      if (busMain.rsp_busy) busyMain++;
      if (busWs0.rsp_busy) busyWs0++;
      if (busWs3.rsp_busy) busyWs3++;
    end
  endtask

  // Holds reset for two edges, checks the reset values, releases reset and
  // counts edges until ready rises, watching for spurious valid pulses.
  task automatic resetAndInit(output int initCycles, output int validSeen);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstReady", {31'h0, busMain.rsp_ready}, 32'h0);
    checkOutput("rstBusy", {31'h0, busMain.rsp_busy}, 32'h0);
    checkOutput("rstValid", {31'h0, busMain.rsp_valid}, 32'h0);
    checkOutput("rstFault", {31'h0, busMain.rsp_fault}, 32'h0);
    checkOutput("rstRdata", busMain.rsp_rdata, 32'h0);
    checkOutput("rstFaultAddr", busMain.fault_addr, 32'h0);
    rst = 1'b0;
    initCycles = 0;
    validSeen = 0;
    while (!busMain.rsp_ready && initCycles < 40) begin
      @(negedge clk);
      initCycles++;
      if (busMain.rsp_valid || busMain.rsp_busy) validSeen++;
    end
  endtask

  initial begin : mainSeq
    int initCycles, validSeen, waited;

    //            w     r     sz     addr          wdata         chkRd expRd         fault expFa
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h0000_1000, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1004, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 2'b10, 32'h0000_1004, 32'h0,        1'b1, 32'hDEADBEEF,  1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h0000_1006, 32'h0000_005A, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, 32'h0000_1004, 32'h0,        1'b1, 32'hDE5ABEEF,  1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 32'h0000_1007, 32'h0,        1'b1, 32'h0000_00DE, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 32'h0000_1006, 32'h0,        1'b1, 32'h0000_DE5A, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'h0000_1002, 32'h0,        1'b1, 32'h0,         1'b1, 32'h0000_1002};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0FFC, 32'h11223344, 1'b1, 32'h0,         1'b1, 32'h0000_0FFC};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1040, 32'h55667788, 1'b1, 32'h0,         1'b1, 32'h0000_1040};
    vecs[10] = '{1'b0, 1'b1, 2'b10, 32'h0000_103C, 32'h0,        1'b1, 32'h0,         1'b0, 32'h0000_1040};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 32'h0000_1008, 32'hAAAA5555, 1'b1, 32'h0,         1'b1, 32'h0000_1008};
    vecs[12] = '{1'b0, 1'b1, 2'b11, 32'h0000_100C, 32'h0,        1'b1, 32'h0,         1'b1, 32'h0000_100C};
    vecs[13] = '{1'b0, 1'b1, 2'b01, 32'h0000_1005, 32'h0,        1'b1, 32'h0,         1'b1, 32'h0000_1005};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 32'h0000_100A, 32'h0000_BEEF, 1'b0, 32'h0,        1'b0, 32'h0000_1005};
    vecs[15] = '{1'b0, 1'b1, 2'b10, 32'h0000_1008, 32'h0,        1'b1, 32'hBEEF0000,  1'b0, 32'h0000_1005};
    vecs[16] = '{1'b0, 1'b1, 2'b00, 32'h0000_1004, 32'h0,        1'b1, 32'h0000_00EF, 1'b0, 32'h0000_1005};
    vecs[17] = '{1'b0, 1'b1, 2'b10, 32'h0000_1004, 32'h0,        1'b1, 32'hDE5ABEEF,  1'b0, 32'h0000_1005};

    resetAndInit(initCycles, validSeen);
    checkOutput("initCycles", initCycles, 32'd16);
    checkOutput("initNoActivity", validSeen, 32'd0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].w, vecs[i].r, vecs[i].sz, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("v%0d latWs1", i), latMain, 32'd2);
      checkOutput($sformatf("v%0d busyWs1", i), busyMain, 32'd2);
      checkOutput($sformatf("v%0d latWs0", i), latWs0, 32'd1);
      checkOutput($sformatf("v%0d busyWs0", i), busyWs0, 32'd1);
      checkOutput($sformatf("v%0d latWs3", i), latWs3, 32'd4);
      checkOutput($sformatf("v%0d busyWs3", i), busyWs3, 32'd4);
      checkOutput($sformatf("v%0d fault", i), {31'h0, fMain}, {31'h0, vecs[i].expFault});
      if (vecs[i].chkRd) begin
        checkOutput($sformatf("v%0d rdata", i), rdMain, vecs[i].expRd);
      end
      checkOutput($sformatf("v%0d faultAddr", i), busMain.fault_addr, vecs[i].expFa);
    end

    // Store 0x1010 then reset while the main responder sits in WAIT and the
    // zero-wait responder sits in RESP; neither may commit the write.
    waited = 0;
    @(negedge clk);
    while (!busMain.rsp_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midReady", {31'h0, busMain.rsp_ready}, 32'h1);
    reqW = 1'b1; reqR = 1'b0; reqSize = 2'b10; reqAddr = 32'h0000_1010; reqWdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reqW = 1'b0;
    @(negedge clk);
    checkOutput("midBusy", {31'h0, busMain.rsp_busy}, 32'h1);
    checkOutput("midNoValid", {31'h0, busMain.rsp_valid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", {31'h0, busMain.rsp_valid}, 32'h0);
    checkOutput("midRstBusy", {31'h0, busMain.rsp_busy}, 32'h0);
    checkOutput("midRstReady", {31'h0, busMain.rsp_ready}, 32'h0);
    resetAndInit(initCycles, validSeen);
    checkOutput("reinitCycles", initCycles, 32'd16);
    checkOutput("reinitNoActivity", validSeen, 32'd0);

    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0000_1010, 32'h0);
    checkOutput("afterRst rdata", rdMain, 32'h0);
    checkOutput("afterRst rdataWs0", rdWs0, 32'h0);
    checkOutput("afterRst fault", {31'h0, fMain}, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0000_1004, 32'h0);
    checkOutput("afterRst cleared", rdMain, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
